gsim_seq_ctrl: RTL and testbench

- Sequencer for the 16-entry x-vector circular shift register in the GSIM solver.
- Runs three phases in order:
  - load: streams 16 initial values into the register.
  - compute: runs ITER Gauss-Seidel sweeps over 16 rows. Each row requests one result from the compute unit, then writes it back in place with a shift-by-1.
  - drain: streams the 16 solved values out under valid/ready.
- Sits between the host interface, the row compute pipeline and the shift register. It owns the register's ctrl, i_en and IN pins.

---
 rtl/gsim_seq_ctrl.sv | 164 ++++++++++++++++
 tb/tb_gsim_seq_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gsim_seq_ctrl.sv
// Sequencer for the GSIM 16-entry x-vector shift register: load, ITER
// Gauss-Seidel sweeps of row requests/write-backs, then a valid/ready drain.
module gsim_seq_ctrl #(
  parameter int BIT_WIDTH = 32,
  parameter int ITER      = 100,
  parameter int ITW       = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [BIT_WIDTH-1:0] in_data,
  output logic                 in_ready,
  output logic [1:0]           sh_ctrl,
  output logic                 sh_ien,
  output logic [BIT_WIDTH-1:0] sh_in,
  input  logic [BIT_WIDTH-1:0] sh_tap,
  output logic                 calc_start,
  output logic [3:0]           calc_row,
  input  logic                 calc_done,
  input  logic [BIT_WIDTH-1:0] calc_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_data,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [1:0]     CTRL_SHIFT1 = 2'b00;
  localparam logic [1:0]     CTRL_HOLD   = 2'b11;
  localparam logic [ITW-1:0] ITER_LAST   = ITW'(ITER - 1);

  state_t         state, state_nx;
  logic [3:0]     row, row_nx;
  logic [ITW-1:0] iter, iter_nx;
  logic [4:0]     shifts, shifts_nx;
  logic [4:0]     beats, beats_nx;
  logic           out_valid_nx;
  logic           shift_ok;
  logic           accept;

  // A drain shift may only happen once the tap value has been consumed.
  assign shift_ok = (state == S_DRAIN) && (!out_valid || out_ready) && (shifts < 5'd16);
  assign accept   = (state == S_DRAIN) && out_valid && out_ready;

  assign calc_row = row;
  assign out_data = sh_tap;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      row       <= '0;
      iter      <= '0;
      shifts    <= '0;
      beats     <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      row       <= row_nx;
      iter      <= iter_nx;
      shifts    <= shifts_nx;
      beats     <= beats_nx;
      out_valid <= out_valid_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    row_nx       = row;
    iter_nx      = iter;
    shifts_nx    = shifts;
    beats_nx     = beats;
    out_valid_nx = out_valid;
    sh_ctrl      = CTRL_HOLD;
    sh_ien       = 1'b0;
    sh_in        = '0;
    in_ready     = 1'b0;
    calc_start   = 1'b0;
    done         = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_LOAD;
          row_nx   = '0;
        end
      end

      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sh_ctrl = CTRL_SHIFT1;
          sh_ien  = 1'b1;
          sh_in   = in_data;
          row_nx  = row + 4'd1;
          if (row == 4'd15) begin
            state_nx = S_ISSUE;
            row_nx   = '0;
            iter_nx  = '0;
          end
        end
      end

      S_ISSUE: begin
        calc_start = 1'b1;
        state_nx   = S_WAIT;
      end

      S_WAIT: begin
        if (calc_done) begin
          sh_ctrl = CTRL_SHIFT1;
          sh_ien  = 1'b1;
          sh_in   = calc_result;
          if (row != 4'd15) begin
            row_nx   = row + 4'd1;
            state_nx = S_ISSUE;
          end else begin
            row_nx = '0;
            if (iter == ITER_LAST) begin
              state_nx  = S_DRAIN;
              shifts_nx = '0;
              beats_nx  = '0;
            end else begin
              iter_nx  = iter + ITW'(1);
              state_nx = S_ISSUE;
            end
          end
        end
      end

      S_DRAIN: begin
        if (shift_ok) begin
          sh_ctrl      = CTRL_SHIFT1;
          shifts_nx    = shifts + 5'd1;
          out_valid_nx = 1'b1;
        end else if (accept) begin
          out_valid_nx = 1'b0;
        end
        if (accept) begin
          beats_nx = beats + 5'd1;
          if (beats == 5'd15) state_nx = S_DONE;
        end
      end

      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end

      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_gsim_seq_ctrl.sv
// Self-checking bench for gsim_seq_ctrl: behavioural shift register and compute
// unit around the DUT, with a reference of the last value written per row.
module tb_gsim_seq_ctrl;

  localparam int BW   = 32;
  localparam int NITR = 2;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic [BW-1:0] in_data;
  logic          in_ready;
  logic [1:0]    sh_ctrl;
  logic          sh_ien;
  logic [BW-1:0] sh_in;
  logic [BW-1:0] sh_tap;
  logic          calc_start;
  logic [3:0]    calc_row;
  logic          calc_done;
  logic          rsp_done;
  logic          inj_done;
  logic [BW-1:0] calc_result;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic          busy;
  logic          done;

  int n_assert = 0;
  int n_fail   = 0;

  logic [BW-1:0] sr [16];
  logic [BW-1:0] exp_x [16];
  int            cs_count = 0;
  int            ien_cnt  = 0;
  logic          resp_en;
  logic          resp_fixed;

  assign calc_done = rsp_done | inj_done;
  assign sh_tap    = sr[15];

  gsim_seq_ctrl #(.BIT_WIDTH(BW), .ITER(NITR), .ITW(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .sh_ctrl(sh_ctrl), .sh_ien(sh_ien), .sh_in(sh_in), .sh_tap(sh_tap),
    .calc_start(calc_start), .calc_row(calc_row),
    .calc_done(calc_done), .calc_result(calc_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Behavioural 16-entry circular shift register driven by the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) sr[i] <= '0;
    end else begin
      case (sh_ctrl)
        2'b00: begin
          for (int i = 0; i < 15; i++) sr[i] <= sr[i+1];
          sr[15] <= sh_ien ? sh_in : sr[0];
        end
        2'b01: for (int i = 0; i < 16; i++) sr[i] <= sr[(i+4)%16];
        2'b10: for (int i = 0; i < 16; i++) sr[i] <= sr[(i+5)%16];
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ctrl_legal", 32'(sh_ctrl == 2'b01 || sh_ctrl == 2'b10), 0);
      chk("out_data_tap", out_data, sh_tap);
      if (sh_ien && sh_ctrl == 2'b00) ien_cnt++;
    end
  end

  // Compute unit model: answers each request after a latency of 1..4 cycles.
  initial begin : responder
    int       rrow;
    int       lat;
    logic [BW-1:0] val;
    rsp_done    = 1'b0;
    calc_result = '0;
    rrow        = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) rrow = 0;
      else if (calc_start) begin
        chk("calc_row", calc_row, 32'(rrow));
        cs_count++;
        val  = resp_fixed ? BW'(100 + rrow) : $urandom;
        lat  = resp_fixed ? 3 : int'($urandom_range(1, 4));
        repeat (lat) @(posedge clk);
        #1;
        if (rst_n && resp_en) begin
          rsp_done    = 1'b1;
          calc_result = val;
          @(negedge clk);
          chk("wr_ctrl", sh_ctrl, 0);
          chk("wr_ien", sh_ien, 1);
          chk("wr_data", sh_in, val);
          exp_x[rrow] = val;
          rrow = (rrow + 1) % 16;
          @(posedge clk);
          #1;
          rsp_done = 1'b0;
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_ctrl"}, sh_ctrl, 3);
    chk({pfx, "_ien"}, sh_ien, 0);
    chk({pfx, "_cstart"}, calc_start, 0);
    chk({pfx, "_ovalid"}, out_valid, 0);
    chk({pfx, "_iready"}, in_ready, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_busy", busy, 1);
    chk("start_iready", in_ready, 1);
  endtask

  // Streams 1..16 with an in_valid gap every third cycle.
  task automatic do_load(input bit inject);
    int beat = 0;
    int cyc  = 0;
    int ien0 = ien_cnt;
    while (beat < 16 && cyc < 100) begin
      @(posedge clk); #1;
      inj_done = 1'b0;
      if (cyc % 3 == 2) begin
        in_valid = 1'b0;
        inj_done = inject && (cyc == 2);
      end else begin
        in_valid = 1'b1;
        in_data  = BW'(beat + 1);
      end
      @(negedge clk);
      if (in_valid) begin
        chk("ld_ctrl", sh_ctrl, 0);
        chk("ld_ien", sh_ien, 1);
        chk("ld_data", sh_in, 32'(beat + 1));
        beat++;
      end else if (inj_done) begin
        chk("ld_ign_ctrl", sh_ctrl, 3);
        chk("ld_ign_ien", sh_ien, 0);
        chk("ld_ign_iready", in_ready, 1);
      end
      cyc++;
    end
    chk("ld_beats", 32'(beat), 16);
    @(posedge clk); #1;
    in_valid = 1'b0;
    inj_done = 1'b0;
    @(negedge clk);
    chk("ld_writes", 32'(ien_cnt - ien0), 16);
    chk("ld_iready_low", in_ready, 0);
    chk("ld_issue", calc_start, 1);
    chk("ld_issue_row", calc_row, 0);
  endtask

  task automatic poke_start_in_wait(input int base);
    int k = 0;
    while (cs_count - base < 3 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("wait_poll_timeout", 32'(k < 200), 1);
    @(posedge clk); #1;
    start = 1'b1;
    @(negedge clk);
    chk("wait_start_cstart", calc_start, 0);
    chk("wait_start_busy", busy, 1);
    chk("wait_start_iready", in_ready, 0);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_drain(input bit bp);
    int beat  = 0;
    int cyc   = 0;
    int stall = 0;
    int wc    = 0;
    while (!out_valid && wc < 3000) begin
      @(negedge clk);
      wc++;
    end
    chk("drain_wait_timeout", 32'(wc < 3000), 1);
    while (beat < 16 && cyc < 200) begin
      @(posedge clk); #1;
      out_ready = !(bp && beat == 7 && stall < 5);
      @(negedge clk);
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, exp_x[beat]);
      if (out_ready) beat++;
      else begin
        stall++;
        chk("stall_hold", sh_ctrl, 3);
      end
      cyc++;
    end
    chk("drain_beats", 32'(beat), 16);
    chk("drain_cycles", 32'(cyc), bp ? 21 : 16);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_ovalid", out_valid, 0);
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    for (int i = 0; i < 16; i++) chk("final_order", sr[i], exp_x[i]);
  endtask

  initial begin : main
    int base;
    int ien0;
    int k;
    rst_n      = 1'b0;
    start      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    inj_done   = 1'b0;
    resp_en    = 1'b0;
    resp_fixed = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    rst_n   = 1'b1;
    resp_en = 1'b1;

    // Solve A: results row+100, start poked during WAIT, drain backpressure.
    base = cs_count;
    ien0 = ien_cnt;
    do_start();
    do_load(1'b1);
    poke_start_in_wait(base);
    do_drain(1'b1);
    chk("a_requests", 32'(cs_count - base), 32);
    chk("a_writes", 32'(ien_cnt - ien0), 48);

    // Solve B: random results, reset at iteration 1 row 9.
    resp_fixed = 1'b0;
    base = cs_count;
    do_start();
    do_load(1'b0);
    k = 0;
    while (cs_count - base < 26 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("rst_poll_timeout", 32'(k < 3000), 1);
    #1;
    rst_n   = 1'b0;
    resp_en = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    repeat (6) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    resp_en = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);

    // Solve C: random results, clean load after the reset, free-flowing drain.
    base = cs_count;
    ien0 = ien_cnt;
    do_start();
    do_load(1'b0);
    do_drain(1'b0);
    chk("c_requests", 32'(cs_count - base), 32);
    chk("c_writes", 32'(ien_cnt - ien0), 48);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
